// File: rtl/fall_sequencer.sv
// ---------------------------------------------------------------------------
// fall_sequencer
//
// Game-flow controller for a 4-column by 8-row Tetris board with a single
// falling one-cell piece. It owns the settled board, schedules gravity ticks
// against player moves, locks the piece, clears a full row and detects game
// over.
//
// Parameters:
//   FALL_DIV   ACTIVE cycles per gravity step (2..255)
//   SPAWN_COL  column (0..3) where each new piece appears in row 0
//
// Ports:
//   in_clka     input   1   single clock, rising edge
//   in_restart  input   1   synchronous active-high reset
//   in_move     input   2   00 none, 01 left, 10 right, 11 hard drop
//   board_out   output  32  settled board OR active piece (bit = 4*row+col)
//   piece_row   output  3   active piece row (0 = top)
//   piece_col   output  2   active piece column
//   lines_out   output  8   cleared-line count, saturating at 255
//   game_over   output  1   high while in OVER
//   state_out   output  3   SPAWN=0 ACTIVE=1 DROP=2 LOCK=3 CLEAR=4 OVER=5
// ---------------------------------------------------------------------------
module fall_sequencer #(
    parameter int FALL_DIV  = 4,
    parameter int SPAWN_COL = 1
) (
    input  logic        in_clka,
    input  logic        in_restart,
    input  logic [1:0]  in_move,
    output logic [31:0] board_out,
    output logic [2:0]  piece_row,
    output logic [1:0]  piece_col,
    output logic [7:0]  lines_out,
    output logic        game_over,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        SPAWN  = 3'd0,
        ACTIVE = 3'd1,
        DROP   = 3'd2,
        LOCK   = 3'd3,
        CLEAR  = 3'd4,
        OVER   = 3'd5
    } state_t;

    localparam logic [7:0] TICK_LAST = 8'(FALL_DIV - 1);
    localparam logic [1:0] SPAWN_C   = 2'(SPAWN_COL);

    state_t      state;
    state_t      next_state;
    logic [31:0] settled;
    logic [31:0] cleared_board;
    logic [7:0]  tick_cnt;
    logic [1:0]  prev_move;

    logic        press;
    logic        is_tick;
    logic [4:0]  piece_idx;
    logic [4:0]  below_idx;
    logic [4:0]  left_idx;
    logic [4:0]  right_idx;
    logic        below_free;
    logic        left_free;
    logic        right_free;
    logic        spawn_blocked;
    logic        row_full;

    // Board lookups around the active piece. A 5-bit {row, col} index is
    // exactly 4*row + col, so it addresses the flat board directly. The
    // neighbour indices may wrap at the edges; the row/col guards mask that.
    always_comb begin
        piece_idx     = {piece_row, piece_col};
        below_idx     = {3'(piece_row + 3'd1), piece_col};
        left_idx      = {piece_row, 2'(piece_col - 2'd1)};
        right_idx     = {piece_row, 2'(piece_col + 2'd1)};
        below_free    = (piece_row != 3'd7) && !settled[below_idx];
        left_free     = (piece_col != 2'd0) && !settled[left_idx];
        right_free    = (piece_col != 2'd3) && !settled[right_idx];
        spawn_blocked = settled[SPAWN_COL];
        row_full      = (settled[{piece_row, 2'b00} +: 4] == 4'hF);
        press         = (in_move != 2'b00) && (in_move != prev_move);
        is_tick       = (tick_cnt == TICK_LAST);
    end

    // Board after a line clear at the piece row: every row at or above the
    // piece row shifts down by one and the top row empties; rows below the
    // piece row are untouched.
    always_comb begin
        cleared_board = settled;
        for (int r = 0; r < 8; r++) begin
            if (r <= int'(piece_row)) begin
                if (r == 0) begin
                    cleared_board[3:0] = 4'h0;
                end else begin
                    cleared_board[4*r +: 4] = settled[4*(r-1) +: 4];
                end
            end
        end
    end

    // State register.
    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            state <= SPAWN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Gravity wins over any command on a tick cycle, so a
    // hard drop is only honoured on non-tick cycles.
    always_comb begin
        next_state = state;
        case (state)
            SPAWN:   next_state = spawn_blocked ? OVER : ACTIVE;
            ACTIVE: begin
                if (is_tick) begin
                    if (!below_free) begin
                        next_state = LOCK;
                    end
                end else if (press && (in_move == 2'b11)) begin
                    next_state = DROP;
                end
            end
            DROP: begin
                if (!below_free) begin
                    next_state = LOCK;
                end
            end
            LOCK:    next_state = CLEAR;
            CLEAR:   next_state = SPAWN;
            OVER:    next_state = OVER;
            default: next_state = SPAWN;
        endcase
    end

    // Datapath registers: piece position, tick counter, settled board, line
    // count and the previous-move register used for press-edge detection.
    // The previous-move register tracks in_move every cycle in every state
    // so a command held across a tick or a state change still acts once.
    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            settled   <= 32'd0;
            piece_row <= 3'd0;
            piece_col <= SPAWN_C;
            lines_out <= 8'd0;
            tick_cnt  <= 8'd0;
            prev_move <= 2'b00;
        end else begin
            prev_move <= in_move;
            case (state)
                SPAWN: begin
                    if (!spawn_blocked) begin
                        piece_row <= 3'd0;
                        piece_col <= SPAWN_C;
                        tick_cnt  <= 8'd0;
                    end
                end
                ACTIVE: begin
                    if (is_tick) begin
                        tick_cnt <= 8'd0;
                        if (below_free) begin
                            piece_row <= piece_row + 3'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 8'd1;
                        if (press) begin
                            if ((in_move == 2'b01) && left_free) begin
                                piece_col <= piece_col - 2'd1;
                            end else if ((in_move == 2'b10) && right_free) begin
                                piece_col <= piece_col + 2'd1;
                            end
                        end
                    end
                end
                DROP: begin
                    if (below_free) begin
                        piece_row <= piece_row + 3'd1;
                    end
                end
                LOCK: begin
                    settled[piece_idx] <= 1'b1;
                end
                CLEAR: begin
                    if (row_full) begin
                        settled <= cleared_board;
                        if (lines_out != 8'hFF) begin
                            lines_out <= lines_out + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode. The piece is only overlaid while it is actually
    // falling; in every other state the board shows settled cells only.
    always_comb begin
        board_out = settled;
        if ((state == ACTIVE) || (state == DROP)) begin
            board_out = settled | (32'd1 << piece_idx);
        end
        game_over = (state == OVER);
        state_out = state;
    end

endmodule

// File: tb/tb_fall_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fall_sequencer
//
// Directed testbench for fall_sequencer with FALL_DIV=4 and SPAWN_COL=1.
// Inputs change 1 time unit after each rising edge and outputs are sampled
// at the same point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_fall_sequencer;

    logic        in_clka;
    logic        in_restart;
    logic [1:0]  in_move;
    logic [31:0] board_out;
    logic [2:0]  piece_row;
    logic [1:0]  piece_col;
    logic [7:0]  lines_out;
    logic        game_over;
    logic [2:0]  state_out;

    int vector_count    = 0;
    int miscompare_count = 0;

    fall_sequencer #(
        .FALL_DIV  (4),
        .SPAWN_COL (1)
    ) dut (
        .in_clka    (in_clka),
        .in_restart (in_restart),
        .in_move    (in_move),
        .board_out  (board_out),
        .piece_row  (piece_row),
        .piece_col  (piece_col),
        .lines_out  (lines_out),
        .game_over  (game_over),
        .state_out  (state_out)
    );

    // Free-running clock, 10 time-unit period.
    initial in_clka = 1'b0;
    always #5 in_clka = ~in_clka;

    // Hold a move value for a number of rising edges, leaving the bench
    // 1 time unit past the last edge.
    task automatic applyStimulus(input logic [1:0] move, input int cycles);
        in_move = move;
        for (int i = 0; i < cycles; i++) begin
            @(posedge in_clka);
            #1;
        end
    endtask

    // Single comparison point: counts every vector and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vector_count++;
        if (actual !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One reset edge; afterwards the design sits in SPAWN.
    task automatic doReset();
        in_restart = 1'b1;
        applyStimulus(2'b00, 1);
        in_restart = 1'b0;
    endtask

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_restart = 1'b1;
        in_move    = 2'b00;

        // Reset state and free fall.
        doReset();
        checkOutput("rst_board", board_out, 32'h0);
        checkOutput("rst_state", 32'(state_out), 32'd0);
        checkOutput("rst_row", 32'(piece_row), 32'd0);
        checkOutput("rst_col", 32'(piece_col), 32'd1);
        checkOutput("rst_lines", 32'(lines_out), 32'd0);
        checkOutput("rst_over", 32'(game_over), 32'd0);
        applyStimulus(2'b00, 1);
        checkOutput("ff_spawn_board", board_out, 32'h0000_0002);
        checkOutput("ff_spawn_state", 32'(state_out), 32'd1);
        applyStimulus(2'b00, 28);
        checkOutput("ff_row7_board", board_out, 32'h2000_0000);
        checkOutput("ff_row7_row", 32'(piece_row), 32'd7);
        applyStimulus(2'b00, 4);
        checkOutput("ff_lock_state", 32'(state_out), 32'd3);
        checkOutput("ff_lock_board", board_out, 32'h0);
        applyStimulus(2'b00, 1);
        checkOutput("ff_clear_state", 32'(state_out), 32'd4);
        checkOutput("ff_clear_board", board_out, 32'h2000_0000);
        applyStimulus(2'b00, 2);
        checkOutput("ff_next_board", board_out, 32'h2000_0002);
        checkOutput("ff_next_state", 32'(state_out), 32'd1);

        // Move edge: a held left acts once; left at col 0 is ignored.
        doReset();
        applyStimulus(2'b00, 1);
        applyStimulus(2'b01, 3);
        checkOutput("mv_held_left", 32'(piece_col), 32'd0);
        applyStimulus(2'b00, 1);
        checkOutput("mv_tick_row", 32'(piece_row), 32'd1);
        applyStimulus(2'b01, 1);
        checkOutput("mv_left_wall", 32'(piece_col), 32'd0);

        // Right presses up to col 3, then one more against the wall.
        doReset();
        applyStimulus(2'b00, 1);
        applyStimulus(2'b10, 1);
        checkOutput("mv_right1", 32'(piece_col), 32'd2);
        applyStimulus(2'b00, 1);
        applyStimulus(2'b10, 1);
        checkOutput("mv_right2", 32'(piece_col), 32'd3);
        applyStimulus(2'b00, 1);
        applyStimulus(2'b10, 1);
        checkOutput("mv_right_wall", 32'(piece_col), 32'd3);
        checkOutput("mv_right_row", 32'(piece_row), 32'd1);

        // Gravity priority: fresh right press lands on the tick cycle.
        doReset();
        applyStimulus(2'b00, 1);
        applyStimulus(2'b00, 3);
        applyStimulus(2'b10, 1);
        checkOutput("gp_tick_row", 32'(piece_row), 32'd1);
        checkOutput("gp_tick_col", 32'(piece_col), 32'd1);
        applyStimulus(2'b10, 3);
        checkOutput("gp_held_col", 32'(piece_col), 32'd1);
        checkOutput("gp_held_row", 32'(piece_row), 32'd1);

        // Line clear: four hard drops across columns 0..3.
        doReset();
        applyStimulus(2'b00, 1);
        applyStimulus(2'b01, 1);
        applyStimulus(2'b11, 1);
        applyStimulus(2'b00, 8);
        checkOutput("lc_a_lock", 32'(state_out), 32'd3);
        applyStimulus(2'b00, 3);
        checkOutput("lc_a_board", board_out, 32'h1000_0002);
        applyStimulus(2'b11, 1);
        applyStimulus(2'b00, 11);
        checkOutput("lc_b_board", board_out, 32'h3000_0002);
        applyStimulus(2'b10, 1);
        applyStimulus(2'b11, 1);
        applyStimulus(2'b00, 11);
        checkOutput("lc_c_board", board_out, 32'h7000_0002);
        applyStimulus(2'b10, 1);
        applyStimulus(2'b00, 1);
        applyStimulus(2'b10, 1);
        applyStimulus(2'b00, 1);
        applyStimulus(2'b11, 1);
        applyStimulus(2'b00, 7);
        checkOutput("lc_d_lock_state", 32'(state_out), 32'd3);
        checkOutput("lc_d_lock_board", board_out, 32'h7000_0000);
        applyStimulus(2'b00, 1);
        checkOutput("lc_clear_state", 32'(state_out), 32'd4);
        checkOutput("lc_clear_board", board_out, 32'hF000_0000);
        applyStimulus(2'b00, 1);
        checkOutput("lc_settled", board_out, 32'h0);
        checkOutput("lc_lines", 32'(lines_out), 32'd1);
        applyStimulus(2'b00, 1);
        checkOutput("lc_respawn", board_out, 32'h0000_0002);

        // Game over: stack eight pieces in column 1.
        doReset();
        applyStimulus(2'b00, 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2'b11, 1);
            applyStimulus(2'b00, 11 - i);
            if (i < 7) begin
                checkOutput($sformatf("go_stack%0d", i), 32'(state_out), 32'd1);
            end
        end
        checkOutput("go_state", 32'(state_out), 32'd5);
        checkOutput("go_flag", 32'(game_over), 32'd1);
        checkOutput("go_board", board_out, 32'h2222_2222);
        applyStimulus(2'b01, 1);
        applyStimulus(2'b00, 1);
        applyStimulus(2'b11, 1);
        applyStimulus(2'b00, 1);
        checkOutput("go_hold_state", 32'(state_out), 32'd5);
        checkOutput("go_hold_board", board_out, 32'h2222_2222);
        checkOutput("go_hold_lines", 32'(lines_out), 32'd0);

        // Reset in the middle of a hard drop.
        doReset();
        applyStimulus(2'b00, 1);
        applyStimulus(2'b11, 1);
        applyStimulus(2'b00, 2);
        checkOutput("mr_in_drop", 32'(state_out), 32'd2);
        in_restart = 1'b1;
        applyStimulus(2'b00, 1);
        in_restart = 1'b0;
        checkOutput("mr_board", board_out, 32'h0);
        checkOutput("mr_lines", 32'(lines_out), 32'd0);
        checkOutput("mr_state", 32'(state_out), 32'd0);
        applyStimulus(2'b00, 1);
        checkOutput("mr_respawn", board_out, 32'h0000_0002);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule

// File: doc/fall_sequencer.md
# fall_sequencer

Game-flow controller for the Tetris board datapath. It owns the 4-column by 8-row settled board and one falling single-cell piece. It schedules gravity ticks against player moves, locks the piece, clears full rows and detects game over. It drives the 32-bit board image the top level exports, and it runs on a single clock.

## Interface
Parameters:
- FALL_DIV, default 4: ACTIVE cycles per gravity step; legal range 2..255.
- SPAWN_COL, default 1: column (0..3) where each new piece appears in row 0.

Ports:
- in_clka, input, 1: the only clock; all state updates on its rising edge.
- in_restart, input, 1: synchronous, active-high reset.
- in_move, input, 2: player command.
  - 00: none
  - 01: left
  - 10: right
  - 11: hard drop
- board_out, output, 32: settled board OR active-piece cell.
  - Bit index is 4*row + col.
  - Row 0 is the top row and col 0 is the LSB of each row.
- piece_row, output, 3: active piece row.
- piece_col, output, 2: active piece column.
- lines_out, output, 8: cleared-line count.
- game_over, output, 1: high while in OVER.
- state_out, output, 3: state code.
  - SPAWN=0, ACTIVE=1, DROP=2, LOCK=3, CLEAR=4, OVER=5

## Operation
Command acceptance:
- A command is accepted only on a press edge: in_move is nonzero and differs from the in_move value registered on the previous cycle.
- The previous-value register updates every cycle in every state.
- A held command therefore acts once.

States and transitions:
- SPAWN (1 cycle):
  - If settled cell (0, SPAWN_COL) is occupied, go to OVER.
  - Otherwise set the piece to (0, SPAWN_COL), clear the tick counter and go to ACTIVE.
- ACTIVE:
  - The tick counter increments each cycle.
  - On a tick cycle (counter == FALL_DIV-1), the counter returns to 0.
    - If row < 7 and the cell below is empty, row increments.
    - Otherwise go to LOCK.
    - Any command in a tick cycle is discarded, because gravity has priority.
  - On a non-tick cycle, an accepted command acts as follows.
    - left: col-1 if col > 0 and the target cell is empty; otherwise ignored.
    - right: col+1 if col < 3 and the target cell is empty; otherwise ignored.
    - hard drop: go to DROP; the position is unchanged this cycle.
- DROP: each cycle, row+1 if row < 7 and the cell below is empty; otherwise go to LOCK. Commands are ignored.
- LOCK (1 cycle): OR the piece cell into the settled board, then go to CLEAR.
- CLEAR (1 cycle):
  - If the piece's row is all ones, perform a line clear:
    - each row r ≤ piece_row takes the contents of row r-1;
    - row 0 becomes 0;
    - lines_out increments, saturating at 255.
  - Only the piece's row can become full, so one check is sufficient. Then go to SPAWN.
- OVER: all state holds and commands are ignored until in_restart.

board_out composition:
- board_out = settled | piece mask.
- The piece mask is applied only in ACTIVE and DROP.
- In SPAWN, LOCK, CLEAR and OVER, board_out shows settled bits only.

## Timing
Reset:
- While in_restart is sampled high at an edge, that edge loads the reset values.
- in_restart has priority in every state, including mid-DROP and OVER.

Reset values:
- settled board 0 and board_out 0
- piece_row 0, piece_col SPAWN_COL
- lines_out 0, game_over 0
- state SPAWN (state_out 0)
- tick counter 0, previous-move register 00

Latencies:
- First edge after reset release: SPAWN to ACTIVE; the piece is visible after that edge.
- Free fall from row 0: the row increments after ACTIVE cycles FALL_DIV, 2·FALL_DIV, …, 7·FALL_DIV. The tick at 8·FALL_DIV moves to LOCK.
- Hard drop from row k: 7-k DROP cycles plus 1 blocked cycle, then LOCK.
- LOCK, CLEAR and SPAWN take 1 cycle each, so the next piece is visible 3 cycles after leaving ACTIVE or DROP.

Other timing rules:
- All outputs are registered or decoded from registers; there is no combinational path from in_move to outputs.
- Moves and gravity never both modify the piece position in the same cycle.

## Test plan
All scenarios use FALL_DIV=4 and SPAWN_COL=1.

- **Free fall:** release reset with in_move=00.
  - After 1 cycle, board_out=0x0000_0002.
  - After 28 more cycles, board_out=0x2000_0000.
  - 4 cycles later, LOCK occurs.
  - 3 cycles after that, board_out=0x2000_0002 and state_out=1.
- **Move edge:** hold in_move=01 for 3 non-tick cycles, then release.
  - piece_col goes 1 to 0 exactly once.
  - A second press at col 0 leaves col 0.
  - A press of 10 from col 3 leaves col 3.
- **Gravity priority:** assert a fresh 10 press exactly on the tick cycle and hold it.
  - Row increments, col stays 1.
  - The held value is not re-accepted on later cycles.
- **Line clear:** hard-drop 4 pieces into cols 0, 1, 2, 3 (position each with left/right before the drop).
  - After the 4th CLEAR, the settled board is 0 and lines_out=1.
  - The next spawn shows board_out=0x0000_0002.
- **Game over:** hard-drop 8 pieces in col 1.
  - The 9th SPAWN goes to OVER with game_over=1, state_out=5 and board_out=0x2222_2222.
  - Further in_move pulses change nothing.
- **Mid-operation reset:** assert in_restart for 1 cycle during DROP.
  - The next edge gives board_out=0, lines_out=0 and state_out=0.
  - The following edge gives board_out=0x0000_0002.
